instr_fetch_unit: RTL and testbench

Produces the 16-bit instruction stream consumed by the instruction decoder; it is the issuing end of the decoder's instruction interface. It owns the 10-bit program counter, reads instruction memory, presents one instruction at a time to the decoder with a valid/ready handshake, and waits for execute completion. It then resolves the next PC from the decoded jump controls and the ALU flags. It is single-issue with one outstanding fetch, and sits between instruction memory and the decoder/execute stage.

---
 rtl/rns_cpu_pkg.sv | 38 +++
 rtl/branch_resolve.sv | 32 +++
 rtl/instr_fetch_unit.sv | 110 +++++++++++
 tb/tb_instr_fetch_unit.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/rns_cpu_pkg.sv
// Shared CPU definitions: opcode constants, fetch FSM states, default widths,
// and packed bundles for the decoded jump controls and the ALU flags.
package rns_cpu_pkg;

  localparam int ADDR_W_DEF  = 10;
  localparam int INSTR_W_DEF = 16;

  localparam logic [4:0] OP_JMP   = 5'b00111;
  localparam logic [4:0] OP_JMPGT = 5'b01110;
  localparam logic [4:0] OP_JMPLT = 5'b01111;
  localparam logic [4:0] OP_JMPEQ = 5'b10000;
  localparam logic [4:0] OP_JMPC  = 5'b10001;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FETCH,
    ST_WAIT,
    ST_ISSUE,
    ST_EXEC
  } fetch_state_e;

  typedef struct packed {
    logic jump_true;
    logic uncond;
    logic gt;
    logic lt;
    logic eq;
    logic carry;
  } jump_ctl_t;

  typedef struct packed {
    logic gt;
    logic lt;
    logic eq;
    logic carry;
  } alu_flags_t;

endpackage

// File: rtl/branch_resolve.sv
// Combinational next-PC resolution.
//   ctl         decoded jump controls
//   flags       registered ALU flags
//   pc          address of the instruction that just executed
//   branch_addr decoded jump target
//   taken       jump is taken
//   next_pc     branch_addr when taken, else pc+1 (wraps at 2^ADDR_W)
module branch_resolve
  import rns_cpu_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF
) (
  input  jump_ctl_t         ctl,
  input  alu_flags_t        flags,
  input  logic [ADDR_W-1:0] pc,
  input  logic [ADDR_W-1:0] branch_addr,
  output logic              taken,
  output logic [ADDR_W-1:0] next_pc
);

  logic cond_hit;

  // jump_true gates everything; any matching condition bit is enough.
  assign cond_hit = ctl.uncond
                  | (ctl.gt    & flags.gt)
                  | (ctl.lt    & flags.lt)
                  | (ctl.eq    & flags.eq)
                  | (ctl.carry & flags.carry);
  assign taken    = ctl.jump_true & cond_hit;
  assign next_pc  = taken ? branch_addr : pc + 1'b1;

endmodule

// File: rtl/instr_fetch_unit.sv
// Instruction fetch unit: owns the PC, reads instruction memory (one
// outstanding request), issues one instruction to the decoder with a
// valid/ready handshake, waits for execute completion, then resolves the
// next PC from the jump controls and ALU flags.
//   clk, rst_n                 clock, async active-low reset
//   run                        fetch enable (sampled in IDLE and on exec_done)
//   imem_req/addr              one-cycle read strobe, address = pc
//   imem_rvalid/rdata          read response, any latency >= 1
//   instruction/instr_valid    held instruction to decoder
//   instr_ready                decoder accepts
//   pc_out                     address of the held instruction
//   exec_done                  held instruction finished, flags valid
//   jump_*, branch_addr        decoded jump controls / target
//   flag_*                     ALU flags
//   retired_count              exec_done pulses taken in EXEC, wraps
module instr_fetch_unit
  import rns_cpu_pkg::*;
#(
  parameter int                ADDR_W   = ADDR_W_DEF,
  parameter int                INSTR_W  = INSTR_W_DEF,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               run,
  output logic               imem_req,
  output logic [ADDR_W-1:0]  imem_addr,
  input  logic               imem_rvalid,
  input  logic [INSTR_W-1:0] imem_rdata,
  output logic [INSTR_W-1:0] instruction,
  output logic               instr_valid,
  input  logic               instr_ready,
  output logic [ADDR_W-1:0]  pc_out,
  input  logic               exec_done,
  input  logic               jump_true,
  input  logic               unconditional_jump,
  input  logic               jump_gt,
  input  logic               jump_lt,
  input  logic               jump_eq,
  input  logic               jump_carry,
  input  logic [ADDR_W-1:0]  branch_addr,
  input  logic               flag_gt,
  input  logic               flag_lt,
  input  logic               flag_eq,
  input  logic               flag_carry,
  output logic [15:0]        retired_count
);

  fetch_state_e      state, state_nxt;
  logic [ADDR_W-1:0] pc;
  logic [ADDR_W-1:0] next_pc;
  logic              taken;
  jump_ctl_t         ctl;
  alu_flags_t        flags;
  logic              retire;

  assign ctl   = '{jump_true: jump_true, uncond: unconditional_jump, gt: jump_gt,
                   lt: jump_lt, eq: jump_eq, carry: jump_carry};
  assign flags = '{gt: flag_gt, lt: flag_lt, eq: flag_eq, carry: flag_carry};

  branch_resolve #(.ADDR_W(ADDR_W)) u_br (
    .ctl         (ctl),
    .flags       (flags),
    .pc          (pc),
    .branch_addr (branch_addr),
    .taken       (taken),
    .next_pc     (next_pc)
  );

  assign retire = (state == ST_EXEC) && exec_done;

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:  if (run) state_nxt = ST_FETCH;
      ST_FETCH: state_nxt = ST_WAIT;
      ST_WAIT:  if (imem_rvalid) state_nxt = ST_ISSUE;
      ST_ISSUE: if (instr_ready) state_nxt = ST_EXEC;
      ST_EXEC:  if (exec_done) state_nxt = run ? ST_FETCH : ST_IDLE;
      default:  state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= ST_IDLE;
      pc            <= RESET_PC;
      instruction   <= '0;
      retired_count <= '0;
    end else begin
      state <= state_nxt;
      if (state == ST_WAIT && imem_rvalid) instruction <= imem_rdata;
      if (retire) begin
        pc            <= next_pc;
        retired_count <= retired_count + 16'd1;
      end
    end
  end

  // Outputs decode straight from the registered state so the strobe lasts
  // exactly the FETCH cycle and valid drops the cycle after the handshake.
  assign imem_req    = (state == ST_FETCH);
  assign imem_addr   = pc;
  assign instr_valid = (state == ST_ISSUE);
  assign pc_out      = pc;

  logic unused_taken;
  assign unused_taken = taken;

endmodule

// File: tb/tb_instr_fetch_unit.sv
module tb_instr_fetch_unit;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        run = 1'b0;
  logic        imem_req;
  logic [9:0]  imem_addr;
  logic        imem_rvalid = 1'b0;
  logic [15:0] imem_rdata = '0;
  logic [15:0] instruction;
  logic        instr_valid;
  logic        instr_ready = 1'b0;
  logic [9:0]  pc_out;
  logic        exec_done = 1'b0;
  logic        jump_true = 0, unconditional_jump = 0, jump_gt = 0, jump_lt = 0,
               jump_eq = 0, jump_carry = 0;
  logic [9:0]  branch_addr = '0;
  logic        flag_gt = 0, flag_lt = 0, flag_eq = 0, flag_carry = 0;
  logic [15:0] retired_count;

  instr_fetch_unit dut (
    .clk(clk), .rst_n(rst_n), .run(run),
    .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
    .instruction(instruction), .instr_valid(instr_valid),
    .instr_ready(instr_ready), .pc_out(pc_out), .exec_done(exec_done),
    .jump_true(jump_true), .unconditional_jump(unconditional_jump),
    .jump_gt(jump_gt), .jump_lt(jump_lt), .jump_eq(jump_eq),
    .jump_carry(jump_carry), .branch_addr(branch_addr),
    .flag_gt(flag_gt), .flag_lt(flag_lt), .flag_eq(flag_eq),
    .flag_carry(flag_carry), .retired_count(retired_count)
  );

  always #5 clk = ~clk;

  int          errs = 0;
  int          checks = 0;
  int          mem_lat = 2;
  bit          rv_chk_en = 1'b1;
  int          exp_ret = 0;
  logic [9:0]  cur_pc = '0;
  logic [9:0]  exp_addr_q[$];
  logic [25:0] exp_instr_q[$];

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  function automatic logic [15:0] mem_word(input logic [9:0] a);
    return 16'h0801 ^ {a, 6'b0};
  endfunction

  // instruction memory: responds mem_lat cycles after the strobe
  initial begin : mem_model
    logic [9:0] a;
    forever begin
      @(posedge clk); #1;
      if (imem_req) begin
        a = imem_addr;
        repeat (mem_lat) @(posedge clk);
        #1;
        imem_rvalid = 1'b1;
        imem_rdata  = mem_word(a);
        @(posedge clk); #1;
        imem_rvalid = 1'b0;
        if (rv_chk_en) chk("rvalid_to_valid", 32'(instr_valid), 32'd1);
      end
    end
  end

  // scoreboard: fetch addresses and issued instructions
  initial begin : monitor
    logic [9:0]  ea;
    logic [25:0] ei;
    forever begin
      @(negedge clk);
      if (imem_req) begin
        if (exp_addr_q.size() == 0) chk("unexpected_req", 32'(imem_req), 32'd0);
        else begin
          ea = exp_addr_q.pop_front();
          chk("fetch_addr", 32'(imem_addr), 32'(ea));
          exp_instr_q.push_back({ea, mem_word(ea)});
        end
      end
      if (instr_valid && instr_ready) begin
        if (exp_instr_q.size() == 0) chk("unexpected_issue", 32'(instr_valid), 32'd0);
        else begin
          ei = exp_instr_q.pop_front();
          chk("issue_instr", 32'(instruction), 32'(ei[15:0]));
          chk("issue_pc", 32'(pc_out), 32'(ei[25:16]));
        end
      end
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  // ctl = {jt,uj,gt,lt,eq,c}; fl = {gt,lt,eq,c}
  task automatic do_instr(input int rdy_dly, input int exec_lat, input logic [5:0] ctl,
                          input logic [3:0] fl, input logic [9:0] baddr,
                          input logic run_after, input logic [9:0] exp_next);
    int n = 0;
    while (!instr_valid && n < 100) begin @(posedge clk); #1; n++; end
    if (!instr_valid) begin
      chk("valid_timeout", 32'(instr_valid), 32'd1);
      return;
    end
    chk("held_instr", 32'(instruction), 32'(mem_word(cur_pc)));
    chk("held_pc", 32'(pc_out), 32'(cur_pc));
    repeat (rdy_dly) begin
      @(posedge clk); #1;
      chk("bp_valid", 32'(instr_valid), 32'd1);
      chk("bp_instr", 32'(instruction), 32'(mem_word(cur_pc)));
      chk("bp_pc", 32'(pc_out), 32'(cur_pc));
      chk("bp_noreq", 32'(imem_req), 32'd0);
    end
    instr_ready = 1'b1;
    @(posedge clk); #1;
    instr_ready = 1'b0;
    chk("valid_drop", 32'(instr_valid), 32'd0);
    repeat (exec_lat) @(posedge clk);
    #0;
    {jump_true, unconditional_jump, jump_gt, jump_lt, jump_eq, jump_carry} = ctl;
    {flag_gt, flag_lt, flag_eq, flag_carry} = fl;
    branch_addr = baddr;
    run = run_after;
    exec_done = 1'b1;
    if (run_after) exp_addr_q.push_back(exp_next);
    @(posedge clk); #1;
    exec_done = 1'b0;
    {jump_true, unconditional_jump, jump_gt, jump_lt, jump_eq, jump_carry} = '0;
    exp_ret++;
    cur_pc = exp_next;
    chk("retired", 32'(retired_count), 32'(exp_ret));
    chk("next_pc", 32'(pc_out), 32'(exp_next));
    if (run_after) chk("done_to_req", 32'(imem_req), 32'd1);
    else           chk("stop_noreq", 32'(imem_req), 32'd0);
  endtask

  initial begin : main
    int n;
    #2;
    chk("rst_valid", 32'(instr_valid), 32'd0);
    chk("rst_req", 32'(imem_req), 32'd0);
    chk("rst_instr", 32'(instruction), 32'd0);
    chk("rst_pc", 32'(pc_out), 32'd0);
    chk("rst_retired", 32'(retired_count), 32'd0);
    run = 1'b1;
    exp_addr_q.push_back(10'h000);
    @(negedge clk) rst_n = 1'b1;

    do_instr(0, 1, 6'b000000, 4'b0000, 10'h000, 1'b1, 10'h001);   // ADD
    do_instr(0, 1, 6'b110000, 4'b0000, 10'h155, 1'b1, 10'h155);   // JMP
    mem_lat = 3;
    do_instr(0, 2, 6'b100010, 4'b0010, 10'h005, 1'b1, 10'h005);   // JMPEQ taken
    do_instr(0, 1, 6'b100010, 4'b1101, 10'h020, 1'b1, 10'h006);   // JMPEQ not taken
    do_instr(0, 1, 6'b110000, 4'b0000, 10'h005, 1'b1, 10'h005);
    do_instr(0, 1, 6'b100010, 4'b0010, 10'h020, 1'b1, 10'h020);   // JMPEQ taken
    mem_lat = 2;
    do_instr(5, 1, 6'b011111, 4'b1111, 10'h3FF, 1'b1, 10'h021);   // jump_true=0
    do_instr(0, 1, 6'b101001, 4'b0001, 10'h3FF, 1'b1, 10'h3FF);   // gt|carry
    do_instr(0, 1, 6'b000000, 4'b1111, 10'h155, 1'b0, 10'h000);   // wrap, stop

    repeat (4) @(posedge clk);
    #1;
    chk("idle_noreq", 32'(imem_req), 32'd0);
    chk("idle_pc", 32'(pc_out), 32'd0);
    chk("idle_valid", 32'(instr_valid), 32'd0);
    exec_done = 1'b1;
    @(posedge clk); #1;
    exec_done = 1'b0;
    chk("idle_done_ignored", 32'(retired_count), 32'(exp_ret));

    exp_addr_q.push_back(10'h000);
    run = 1'b1;
    do_instr(0, 1, 6'b000000, 4'b0000, 10'h000, 1'b0, 10'h001);

    // reset while waiting for memory; response lands after release
    exp_addr_q.push_back(10'h001);
    run = 1'b1;
    n = 0;
    do begin @(posedge clk); #1; n++; end while (!imem_req && n < 20);
    chk("reset_req_seen", 32'(imem_req), 32'd1);
    @(posedge clk); #1;
    rv_chk_en = 1'b0;
    run = 1'b0;
    rst_n = 1'b0;
    #1;
    chk("async_rst_retired", 32'(retired_count), 32'd0);
    chk("async_rst_pc", 32'(pc_out), 32'd0);
    exp_instr_q.delete();
    exp_ret = 0;
    cur_pc = '0;
    #1 rst_n = 1'b1;
    repeat (5) begin
      @(posedge clk); #1;
      chk("post_rst_valid", 32'(instr_valid), 32'd0);
    end
    chk("post_rst_pc", 32'(pc_out), 32'd0);
    chk("post_rst_retired", 32'(retired_count), 32'd0);
    chk("post_rst_req", 32'(imem_req), 32'd0);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
